// File: rtl/bit_sub_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_sub_pkg                                                          |
// | Shared FSM state type and counter sizing helper for bit_sub.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package bit_sub_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } bit_sub_state_e;

  // Counter must reach DATA_WIDTH itself, hence the +1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_fsub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_fsub                                                             |
// | One-bit full subtractor: d = a - b - bin, bout is the borrow out.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bit_fsub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/bit_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bit_sub                                                              |
// | LSB-first bit-serial unsigned subtractor, one bit per ce-cycle.      |
// | Optional zero flag: define BIT_SUB_ZERO_FLAG_EN.                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bit_sub
  import bit_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 1025
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start_sub,
  input  logic [DATA_WIDTH-1:0] in0,
  input  logic [DATA_WIDTH-1:0] in1,
  output logic                  done_sub,
  output logic [DATA_WIDTH-1:0] diff,
  output logic                  borrow,
  output logic                  is_zero
);

  localparam int               c_cnt_w   = cnt_width(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  bit_sub_state_e        r_state;
  bit_sub_state_e        w_next_state;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_diff;
  logic                  r_bw;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  w_d;
  logic                  w_bout;
  logic                  w_load;
  logic                  w_step;
  logic                  w_last;

  // A start request wins over an in-flight bit step (restart semantics).
  assign w_load = ce & start_sub;
  assign w_step = ce & ~start_sub & (r_state == S_RUN);
  assign w_last = (r_cnt == c_last_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_sub) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (start_sub)   w_next_state = S_RUN;
        else if (w_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = start_sub ? S_RUN : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  bit_fsub u_fsub (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bw),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_bw   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_a   <= in0;
      r_b   <= in1;
      r_bw  <= 1'b0;
      r_cnt <= '0;
    end else if (w_step) begin
      // Result bits enter at the MSB so the LSB lands at bit 0 after the last step.
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_diff <= {w_d, r_diff[DATA_WIDTH-1:1]};
      r_bw   <= w_bout;
      r_cnt  <= r_cnt + c_cnt_one;
    end
  end

`ifdef BIT_SUB_ZERO_FLAG_EN
  logic r_any_one;
  logic r_is_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_any_one <= 1'b0;
      r_is_zero <= 1'b0;
    end else if (w_load) begin
      r_any_one <= 1'b0;
      r_is_zero <= 1'b0;
    end else if (w_step) begin
      r_any_one <= r_any_one | w_d;
      if (w_last) r_is_zero <= ~(r_any_one | w_d);
    end
  end

  assign is_zero = r_is_zero;
`else
  assign is_zero = 1'b0;
`endif

  assign done_sub = (r_state == S_DONE);
  assign diff     = r_diff;
  assign borrow   = r_bw;

endmodule
`default_nettype wire

// File: doc/bit_sub.md
BIT_SUB -- requirements
Module: bit_sub

Interface
REQ-001 Parameter DATA_WIDTH, default 1025: operand and result width in bits, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 ce  input  1  clock enable; when low, all state is frozen.
REQ-005 start_sub  input  1  one-cycle request; captures in0/in1 and begins a subtraction.
REQ-006 in0  input  DATA_WIDTH  minuend, unsigned.
REQ-007 in1  input  DATA_WIDTH  subtrahend, unsigned.
REQ-008 done_sub  output  1  one-ce-cycle pulse; diff/borrow/is_zero valid.
REQ-009 diff  output  DATA_WIDTH  (in0 - in1) mod 2^DATA_WIDTH.
REQ-010 borrow  output  1  final borrow; high iff in0 < in1.
REQ-011 is_zero  output  1  high iff diff == 0 (see Configuration).

Function
REQ-012 Bit-serial, LSB-first: one bit per ce-cycle, the opposite direction to the MSB-first serial compare.
REQ-013 FSM states: IDLE, RUN, DONE. IDLE->RUN on start_sub; RUN->DONE after DATA_WIDTH bit cycles; DONE->IDLE on the next ce-cycle.
REQ-014 On start_sub with ce high, operand shift registers load in0/in1, and the running borrow and bit counter clear to 0.
REQ-015 Each RUN ce-cycle, the block computes d = a0 ^ b0 ^ bw and bw' = (!a0 & b0) | (!(a0 ^ b0) & bw) on the operand LSBs.
REQ-016 In the same cycle, d shifts into diff at the MSB (diff moves right one bit) and both operands shift right one bit.
REQ-017 Latency: start_sub accepted in ce-cycle N means done_sub is high in ce-cycle N+DATA_WIDTH+1.
REQ-018 done_sub is high for exactly one ce-cycle; it holds while ce is low.
REQ-019 diff, borrow and is_zero hold their values from done_sub until the next start_sub is accepted.
REQ-020 start_sub during RUN aborts the current operation and restarts with the new operands; no done_sub is issued for the aborted operation.
REQ-021 start_sub in the DONE cycle: done_sub still pulses in that cycle and the new operation starts at the same edge.
REQ-022 The bit counter is $clog2(DATA_WIDTH+1) bits wide; there is no wrap-around inside RUN.

Reset
REQ-023 rst clears the FSM to IDLE and clears all registers: done_sub=0, diff=0, borrow=0, is_zero=0, counter=0.
REQ-024 rst asserted mid-RUN discards the operation; no done_sub follows.

Configuration
REQ-025 Macro BIT_SUB_ZERO_FLAG_EN.
REQ-026 When BIT_SUB_ZERO_FLAG_EN is defined, a sticky OR of every produced d bit is kept and is_zero = !OR at DONE.
REQ-027 When BIT_SUB_ZERO_FLAG_EN is undefined, is_zero is tied to 0 and no zero-tracking logic is built.

Structure
REQ-028 The shared package holds the bit_sub FSM state enum (IDLE/RUN/DONE) and a counter-width function.
REQ-029 The one-bit full subtractor is sub-module bit_fsub (inputs a, b, bin; outputs d, bout), instanced once.

Verification (DATA_WIDTH=8 unless noted)
REQ-030 in0=0xA5, in1=0x3C, start_sub -> done_sub 9 cycles later; diff=0x69, borrow=0, is_zero=0.
REQ-031 in0=0x3C, in1=0xA5 -> diff=0x97, borrow=1; in0=in1=0x5A -> diff=0x00, borrow=0, is_zero=1 (with macro) or 0 (without).
REQ-032 Second start_sub (in0=0xFF, in1=0x01) 3 cycles into RUN -> exactly one done_sub, 9 cycles after the second start; diff=0xFE.
REQ-033 ce held low for 5 cycles mid-RUN and during DONE -> done_sub is delayed by 5 cycles, stays high while ce is low, and the result is unchanged.
REQ-034 rst pulse mid-RUN -> all outputs 0 immediately (asynchronous), no done_sub; a subsequent operation is correct.
REQ-035 DATA_WIDTH=1025 random operands, 1000 runs -> diff/borrow match a reference model; done_sub latency is 1026 every run.
